// File: rtl/btn_intr_if.sv
// Button interrupt bus: debounced press, CPU enable/ack/clear in; request, pending count, overflow out.
interface btn_intr_if #(
    parameter int CNT_W = 4
);
    logic             db_btn;
    logic             intr_en;
    logic             intr_ack;
    logic             clr_ovf;
    logic             intr;
    logic [CNT_W-1:0] pend_cnt;
    logic             overflow;

    modport master (
        output db_btn, intr_en, intr_ack, clr_ovf,
        input  intr, pend_cnt, overflow
    );

    modport slave (
        input  db_btn, intr_en, intr_ack, clr_ovf,
        output intr, pend_cnt, overflow
    );
endinterface

// File: rtl/btn_intr_ctrl.sv
// Converts debounced button presses into CPU interrupt requests with a
// saturating pending counter, sticky overflow flag and post-ack holdoff.
module btn_intr_ctrl #(
    parameter int CNT_W        = 4,
    parameter int HOLDOFF_CLKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    btn_intr_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       HOLD_LAST = 8'(HOLDOFF_CLKS - 1);

    state_t           state_r, state_nxt_s;
    logic             db_q_r;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             ovf_r, ovf_nxt_s;
    logic [7:0]       hold_r, hold_nxt_s;
    logic             intr_r;
    logic             event_s;
    logic             ack_s;

    assign event_s = bus.db_btn & ~db_q_r;
    assign ack_s   = bus.intr_ack & (state_r == ST_REQ);

    // Pending counter and sticky overflow; an overflowing press beats a clear.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (bus.clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
        if (event_s && !ack_s) begin
            if (cnt_r == CNT_MAX) begin
                ovf_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else if (ack_s && !event_s) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Request FSM next state; holdoff decides on the post-update count.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        case (state_r)
            ST_IDLE: begin
                if ((cnt_r != {CNT_W{1'b0}}) && bus.intr_en) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_nxt_s = ST_HOLD;
                    hold_nxt_s  = 8'd0;
                end else if (!bus.intr_en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                hold_nxt_s = hold_r + 8'd1;
                if (hold_r == HOLD_LAST) begin
                    if ((cnt_nxt_s != {CNT_W{1'b0}}) && bus.intr_en) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                hold_nxt_s  = 8'd0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            db_q_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            hold_r  <= 8'd0;
            intr_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            db_q_r  <= bus.db_btn;
            cnt_r   <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
            hold_r  <= hold_nxt_s;
            intr_r  <= (state_nxt_s == ST_REQ);
        end
    end

    assign bus.intr     = intr_r;
    assign bus.pend_cnt = cnt_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_btn_intr_ctrl.sv
// Table-driven, scoreboarded bench for btn_intr_ctrl (CNT_W=4, HOLDOFF_CLKS=4).
module tb_btn_intr_ctrl;
    localparam int CNT_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    btn_intr_if #(.CNT_W(CNT_W)) bus ();

    btn_intr_ctrl #(.CNT_W(CNT_W), .HOLDOFF_CLKS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       intr;
        logic [3:0] pend;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic  db;
        logic  en;
        logic  ack;
        logic  clr;
        exp_t  exp;
        string name;
    } vec_t;

    vec_t  tbl[$];
    exp_t  sb[$];
    string sb_name[$];
    int    errors = 0;
    int    checks = 0;

    function automatic exp_t ex(logic i, int p, logic o);
        exp_t e;
        e.intr = i;
        e.pend = 4'(p);
        e.ovf  = o;
        return e;
    endfunction

    task automatic compare(string name, exp_t want);
        exp_t got;
        got.intr = bus.intr;
        got.pend = bus.pend_cnt;
        got.ovf  = bus.overflow;
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got intr=%0b pend=%0d ovf=%0b, want intr=%0b pend=%0d ovf=%0b",
                     name, $time, got.intr, got.pend, got.ovf, want.intr, want.pend, want.ovf);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, pop it after the edge.
    task automatic step(logic db, logic en, logic ack, logic clr, exp_t e, string name);
        bus.db_btn   = db;
        bus.intr_en  = en;
        bus.intr_ack = ack;
        bus.clr_ovf  = clr;
        sb.push_back(e);
        sb_name.push_back(name);
        @(posedge clk);
        #1;
        compare(sb_name.pop_front(), sb.pop_front());
    endtask

    task automatic add(logic db, logic en, logic ack, logic clr, exp_t e, string name);
        vec_t v;
        v.db = db; v.en = en; v.ack = ack; v.clr = clr; v.exp = e; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i].db, tbl[i].en, tbl[i].ack, tbl[i].clr, tbl[i].exp, tbl[i].name);
        tbl.delete();
    endtask

    // Assert reset mid-cycle and check outputs clear before the next edge.
    task automatic do_reset(string name);
        rst_n        = 1'b0;
        bus.db_btn   = 1'b0;
        bus.intr_en  = 1'b0;
        bus.intr_ack = 1'b0;
        bus.clr_ovf  = 1'b0;
        #2;
        compare(name, ex(1'b0, 0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.db_btn   = 1'b0;
        bus.intr_en  = 1'b0;
        bus.intr_ack = 1'b0;
        bus.clr_ovf  = 1'b0;
        #3;
        do_reset("power_on_reset");

        // Single multi-cycle press, then ack and holdoff back to idle.
        add(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 1, 1'b0), "single_cnt");
        add(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0), "single_intr");
        add(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0), "single_held");
        add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0), "single_wait");
        add(1'b0, 1'b1, 1'b1, 1'b0, ex(1'b0, 0, 1'b0), "single_ack");
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 1'b0), "single_hold");
        run_tbl();

        // Three queued presses: three INTR pulses separated by 4 low cycles.
        add(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 1, 1'b0), "q3_p1");
        add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0), "q3_rise1");
        add(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0), "q3_p2");
        add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0), "q3_gap");
        add(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b1, 3, 1'b0), "q3_p3");
        add(1'b0, 1'b1, 1'b1, 1'b0, ex(1'b0, 2, 1'b0), "q3_ack1");
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 2, 1'b0), "q3_low1");
        add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0), "q3_rise2");
        add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0), "q3_high2");
        add(1'b0, 1'b1, 1'b1, 1'b0, ex(1'b0, 1, 1'b0), "q3_ack2");
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 1, 1'b0), "q3_low2");
        add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0), "q3_rise3");
        add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0), "q3_high3");
        add(1'b0, 1'b1, 1'b1, 1'b0, ex(1'b0, 0, 1'b0), "q3_ack3");
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 1'b0), "q3_idle");
        run_tbl();

        // Build INTR=1 with three pending, then async reset mid-cycle.
        step(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 1, 1'b0), "rst_p1");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0), "rst_req");
        step(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0), "rst_p2");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0), "rst_gap");
        step(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b1, 3, 1'b0), "rst_p3");
        do_reset("mid_op_reset");

        // Press coinciding with ack, stray ack while low, then enable toggling.
        step(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 1, 1'b0), "co_p1");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0), "co_req");
        step(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0), "co_p2");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0), "co_gap");
        step(1'b1, 1'b1, 1'b1, 1'b0, ex(1'b0, 2, 1'b0), "co_press_ack");
        step(1'b0, 1'b1, 1'b1, 1'b0, ex(1'b0, 2, 1'b0), "co_stray_ack");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 2, 1'b0), "co_hold2");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 2, 1'b0), "co_hold3");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0), "co_rereq");
        step(1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 2, 1'b0), "en_drop");
        step(1'b0, 1'b0, 1'b1, 1'b0, ex(1'b0, 2, 1'b0), "en_idle_ack");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0), "en_resume");
        step(1'b0, 1'b1, 1'b1, 1'b0, ex(1'b0, 1, 1'b0), "en_ack");
        do_reset("reset_before_ovf");

        // Saturation with interrupts disabled, then clear/set priority.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, (i > 15) ? 15 : i, i == 16), "sat_press");
            step(1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, (i > 15) ? 15 : i, i == 16), "sat_release");
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 15, 1'b0), "clr_ovf");
        step(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b0, 15, 1'b1), "clr_vs_set");
        step(1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 15, 1'b0), "clr_again");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 15, 1'b0), "sat_resume");
        step(1'b0, 1'b1, 1'b1, 1'b0, ex(1'b0, 14, 1'b0), "sat_ack");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
